// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory responder.
package mem_pkg;

  // Transaction sequencing: accept, optional wait states, one RAM access, response hold.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Bytes per RAM word; the low address bits select a byte within the word.
  localparam int WORD_BYTES = 4;

  // Ceiling log2 for sizing address fields from elaboration-time constants.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM: synchronous write, combinational read, contents not reset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int n_bits      = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [n_bits-1:0]             wdata,
  input  logic [clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [n_bits-1:0]             rdata
);

  logic [n_bits-1:0] r_mem [DEPTH_WORDS];

  // Write port: one word per enabled clock edge.
  // NOTE: no reset on the storage array -- a reset would force flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core load/store port: one word request at a time,
// WAIT_STATES idle cycles between accept and access, response held until taken.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int n_bits      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [n_bits-1:0] req_addr,
  input  logic [n_bits-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [n_bits-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int         AW       = clog2(DEPTH_WORDS);
  localparam int         OFF_BITS = clog2(WORD_BYTES);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  // With no wait states the access happens in the cycle right after accept.
  localparam state_e     AFTER_ACCEPT = (WAIT_STATES > 0) ? WAIT : ACCESS;

  state_e            r_state;
  state_e            w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [n_bits-1:0] r_addr;
  logic [n_bits-1:0] r_wdata;
  logic [n_bits-1:0] r_rdata;
  logic              r_err;
  logic              r_resp_valid;

  logic              w_accept;
  logic              w_aligned;
  logic [AW-1:0]     w_idx;
  logic              w_ram_we;
  logic [n_bits-1:0] w_ram_rdata;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_aligned = (r_addr[OFF_BITS-1:0] == '0);
  // Bits above the word index are dropped, so accesses wrap modulo DEPTH_WORDS.
  assign w_idx     = r_addr[AW+OFF_BITS-1:OFF_BITS];
  assign w_ram_we  = (r_state == ACCESS) && r_we && w_aligned;

  dmem_array #(
    .n_bits      (n_bits),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_idx),
    .wdata (r_wdata),
    .raddr (w_idx),
    .rdata (w_ram_rdata)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and request-ready decode.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = AFTER_ACCEPT;
      end
      WAIT: begin
        if (r_cnt <= 4'd1) w_next = ACCESS;
      end
      ACCESS: w_next = RESP;
      RESP: begin
        if (r_resp_valid && resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= WAIT_INIT;
    end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request latch: fields are frozen at accept, later req_* changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Response registers: data captured in ACCESS, valid raised one edge later,
  // everything held until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCESS: begin
          r_rdata <= (!r_we && w_aligned) ? w_ram_rdata : '0;
          r_err   <= !w_aligned;
        end
        RESP: begin
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: instance A uses WAIT_STATES=2, instance B uses WAIT_STATES=0.
module tb_data_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        valid_a, valid_b;
  logic        we;
  logic [31:0] addr, wdata;
  logic        resp_ready;
  logic        ready_a, ready_b, rvalid_a, rvalid_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b;

  logic        sel_b;
  logic        ready_s, rvalid_s, err_s;
  logic [31:0] rdata_s;

  int checks;
  int errors;

  assign ready_s  = sel_b ? ready_b  : ready_a;
  assign rvalid_s = sel_b ? rvalid_b : rvalid_a;
  assign err_s    = sel_b ? err_b    : err_a;
  assign rdata_s  = sel_b ? rdata_b  : rdata_a;

  data_mem_responder #(.n_bits(32), .DEPTH_WORDS(64), .WAIT_STATES(2)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (valid_a),
    .req_ready  (ready_a),
    .req_we     (we),
    .req_addr   (addr),
    .req_wdata  (wdata),
    .resp_valid (rvalid_a),
    .resp_ready (resp_ready),
    .resp_rdata (rdata_a),
    .resp_err   (err_a)
  );

  data_mem_responder #(.n_bits(32), .DEPTH_WORDS(64), .WAIT_STATES(0)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (valid_b),
    .req_ready  (ready_b),
    .req_we     (we),
    .req_addr   (addr),
    .req_wdata  (wdata),
    .resp_valid (rvalid_b),
    .resp_ready (resp_ready),
    .resp_rdata (rdata_b),
    .resp_err   (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel_b) valid_b = v;
    else       valid_a = v;
  endtask

  // Present a request, wait (bounded) for acceptance, then scramble the inputs.
  task automatic issue_req(input logic t_we, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, output bit ok);
    @(negedge clk);
    we = t_we; addr = t_addr; wdata = t_wdata;
    set_valid(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ready_s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    set_valid(1'b0);
    we = ~t_we; addr = ~t_addr; wdata = ~t_wdata;
  endtask

  // Count edges after the accept edge until resp_valid is seen; -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (rvalid_s) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                     output int lat, output logic [31:0] rd, output logic er);
    bit ok;
    issue_req(t_we, t_addr, t_wdata, ok);
    if (!ok) begin
      lat = -1; rd = 32'hxxxx_xxxx; er = 1'bx;
    end else begin
      wait_resp(lat);
      rd = rdata_s;
      er = err_s;
      finish_resp();
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    bit          ok;

    checks = 0; errors = 0;
    sel_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; we = 1'b0; addr = '0; wdata = '0; resp_ready = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_ready",  {31'd0, ready_a},  32'd1);
    check("rst_rvalid", {31'd0, rvalid_a}, 32'd0);
    check("rst_rdata",  rdata_a,           32'd0);
    check("rst_err",    {31'd0, err_a},    32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Basic store then load, WAIT_STATES=2.
    txn(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    check("st_lat", lat, 32'd4);
    check("st_rdata", rd, 32'd0);
    check("st_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, lat, rd, er);
    check("ld_lat", lat, 32'd4);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", {31'd0, er}, 32'd0);

    // WAIT_STATES=0 instance.
    sel_b = 1'b1;
    txn(1'b1, 32'h0, 32'h12345678, lat, rd, er);
    check("b_st_lat", lat, 32'd2);
    txn(1'b0, 32'h0, 32'h0, lat, rd, er);
    check("b_ld_lat", lat, 32'd2);
    check("b_ld_rdata", rd, 32'h12345678);
    sel_b = 1'b0;

    // Misaligned store must not touch word 0; misaligned load reports err with zero data.
    txn(1'b1, 32'h0, 32'h11223344, lat, rd, er);
    txn(1'b1, 32'h3, 32'hAAAA5555, lat, rd, er);
    check("mis_st_err", {31'd0, er}, 32'd1);
    check("mis_st_rdata", rd, 32'd0);
    txn(1'b0, 32'h0, 32'h0, lat, rd, er);
    check("mis_w0_rdata", rd, 32'h11223344);
    check("mis_w0_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h3, 32'h0, lat, rd, er);
    check("mis_ld_err", {31'd0, er}, 32'd1);
    check("mis_ld_rdata", rd, 32'd0);

    // Address wrap: 0x100 maps to word 0 with 64 words.
    txn(1'b1, 32'h100, 32'h0000CAFE, lat, rd, er);
    txn(1'b0, 32'h0, 32'h0, lat, rd, er);
    check("wrap_rdata", rd, 32'h0000CAFE);

    // Back-pressure: response held while resp_ready=0 and req_valid toggles.
    issue_req(1'b0, 32'h10, 32'h0, ok);
    wait_resp(lat);
    check("hold_lat", lat, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_a = ~valid_a;
      we = 1'b1; addr = 32'h20; wdata = 32'hBAD00000 | i;
      @(posedge clk);
      #1;
      check("hold_rvalid", {31'd0, rvalid_a}, 32'd1);
      check("hold_rdata",  rdata_a,           32'hDEADBEEF);
      check("hold_ready",  {31'd0, ready_a},  32'd0);
    end
    @(negedge clk);
    valid_a = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_rvalid", {31'd0, rvalid_a}, 32'd0);
    check("rel_ready",  {31'd0, ready_a},  32'd1);
    @(negedge clk);
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("noacc_ready",  {31'd0, ready_a},  32'd1);
    check("noacc_rvalid", {31'd0, rvalid_a}, 32'd0);

    // Reset during WAIT of a store aborts it; the prior word survives.
    txn(1'b1, 32'h8, 32'h5A5A0008, lat, rd, er);
    issue_req(1'b1, 32'h8, 32'h11111111, ok);
    check("abort_busy", {31'd0, ready_a}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_ready",  {31'd0, ready_a},  32'd1);
    check("abort_rvalid", {31'd0, rvalid_a}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    txn(1'b0, 32'h8, 32'h0, lat, rd, er);
    check("abort_rdata", rd, 32'h5A5A0008);

    // Reset during RESP clears outputs without waiting for a clock edge.
    issue_req(1'b0, 32'h10, 32'h0, ok);
    wait_resp(lat);
    check("rr_rdata_pre", rdata_a, 32'hDEADBEEF);
    #2 reset_n = 1'b0;
    #1;
    check("rr_rvalid", {31'd0, rvalid_a}, 32'd0);
    check("rr_rdata",  rdata_a,           32'd0);
    check("rr_ready",  {31'd0, ready_a},  32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
